// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, byte width and default
// burst/gap limits reused by the TX arbiter and the RX-side controller.
package uart_pkg;

  localparam int UART_BYTE_W          = 8;
  localparam int UART_DEF_MAX_BURST   = 16;
  localparam int UART_DEF_GAP_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_GRANT   = 3'd1,
    ARB_START   = 3'd2,
    ARB_WAIT_HI = 3'd3,
    ARB_WAIT_LO = 3'd4
  } uart_arb_state_t;

  // Round-robin successor of a requester index.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte streams and transmitter start/data/busy handshake
// shared between the TX arbiter (slave) and its environment (master).
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]             req_valid;
  logic [UART_BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]             req_last;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           tx_start;
  logic [UART_BYTE_W-1:0]         tx_data;
  logic                           tx_busy;
  logic [NUM_REQ-1:0]             grant;
  logic                           active;

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_start, tx_data, grant, active
  );

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_start, tx_data, grant, active
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping around; returns one-hot grant, index and any-flag.
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   off;
  logic               found;
  logic [IDX_W:0]     sum;

  // Rotate so bit 0 is the requester the pointer names.
  assign rot = NUM_REQ'({req_i, req_i} >> ptr_i);

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = IDX_W'(k);
      end
    end
  end

  assign sum   = {1'b0, ptr_i} + {1'b0, off};
  assign idx_o = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                               : sum[IDX_W-1:0];
  assign any_o = found;
  assign gnt_o = found ? (NUM_REQ'(1) << idx_o) : '0;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter among
// NUM_REQ byte-stream requesters; one tx_start per accepted byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MAX_BURST   = UART_DEF_MAX_BURST,
  parameter int GAP_TIMEOUT = UART_DEF_GAP_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_arbiter_if.slave   arb_if
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);

  uart_arb_state_t        state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]       gidx_q, gidx_d;
  logic                   active_q, active_d;
  logic [NUM_REQ-1:0]     req_ready_q, req_ready_d;
  logic                   tx_start_q, tx_start_d;
  logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
  logic [7:0]             byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic                   last_q, last_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                   hi_cnt_q, hi_cnt_d;

  logic [NUM_REQ-1:0]     pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

  logic                   sel_valid, sel_last, sel_ready;
  logic [UART_BYTE_W-1:0] sel_data;
  logic                   accept, byte_done, release_now;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i (arb_if.req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Only the granted requester's lane is ever looked at.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_ready = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx_q == IDX_W'(i)) begin
        sel_valid = arb_if.req_valid[i];
        sel_last  = arb_if.req_last[i];
        sel_ready = req_ready_q[i];
        sel_data  = arb_if.req_data[i*UART_BYTE_W +: UART_BYTE_W];
      end
    end
  end

  assign accept = (state_q == ARB_GRANT) && sel_valid && sel_ready;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    active_d    = active_q;
    tx_data_d   = tx_data_q;
    byte_cnt_d  = byte_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    last_d      = last_q;
    rr_ptr_d    = rr_ptr_q;
    hi_cnt_d    = hi_cnt_q;
    byte_done   = 1'b0;
    release_now = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d    = pick_gnt;
          gidx_d     = pick_idx;
          active_d   = 1'b1;
          byte_cnt_d = '0;
          gap_cnt_d  = '0;
          last_d     = 1'b0;
          state_d    = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (accept) begin
          tx_data_d  = sel_data;
          byte_cnt_d = byte_cnt_q + 8'd1;
          last_d     = sel_last;
          gap_cnt_d  = '0;
          state_d    = ARB_START;
        end else if (!sel_valid) begin
          // Release on the GAP_TIMEOUT-th idle cycle, so the count never overflows.
          if (gap_cnt_q >= GAP_W'(GAP_TIMEOUT - 1)) begin
            release_now = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end else begin
          gap_cnt_d = '0;
        end
      end
      ARB_START: begin
        hi_cnt_d = 1'b0;
        state_d  = ARB_WAIT_HI;
      end
      ARB_WAIT_HI: begin
        // A transmitter that never raises busy is treated as done after 2 cycles.
        if (arb_if.tx_busy) begin
          state_d = ARB_WAIT_LO;
        end else if (hi_cnt_q) begin
          byte_done = 1'b1;
        end else begin
          hi_cnt_d = 1'b1;
        end
      end
      ARB_WAIT_LO: begin
        if (!arb_if.tx_busy) begin
          byte_done = 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    if (byte_done) begin
      if (last_q || (byte_cnt_q == 8'(MAX_BURST))) begin
        release_now = 1'b1;
      end else begin
        state_d   = ARB_GRANT;
        gap_cnt_d = '0;
      end
    end

    if (release_now) begin
      state_d    = ARB_IDLE;
      grant_d    = '0;
      active_d   = 1'b0;
      byte_cnt_d = '0;
      rr_ptr_d   = IDX_W'(rr_next(int'(gidx_q), NUM_REQ));
    end

    tx_start_d  = (state_d == ARB_START);
    req_ready_d = '0;
    if ((state_d == ARB_GRANT) && !arb_if.tx_busy) begin
      req_ready_d = grant_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      active_q    <= 1'b0;
      req_ready_q <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      byte_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      last_q      <= 1'b0;
      rr_ptr_q    <= '0;
      hi_cnt_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      active_q    <= active_d;
      req_ready_q <= req_ready_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      byte_cnt_q  <= byte_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      last_q      <= last_d;
      rr_ptr_q    <= rr_ptr_d;
      hi_cnt_q    <= hi_cnt_d;
    end
  end

  assign arb_if.req_ready = req_ready_q;
  assign arb_if.tx_start  = tx_start_q;
  assign arb_if.tx_data   = tx_data_q;
  assign arb_if.grant     = grant_q;
  assign arb_if.active    = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-requester byte drivers, a
// transmitter busy model and a scoreboard of expected (requester, byte).
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ     (N),
    .MAX_BURST   (16),
    .GAP_TIMEOUT (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .arb_if (bus.slave)
  );

  typedef struct {
    int         r;
    logic [7:0] d;
  } sb_t;

  sb_t  sb[$];
  int   start_cyc[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   start_cnt = 0;
  int   ready_cyc[N];
  logic [8:0] mem [N][64];
  int   head[N];
  int   tail[N];
  bit   busy_en = 1'b1;
  int   frame = 20;

  task automatic load(input int r, input logic [7:0] d, input logic l);
    mem[r][tail[r]] = {l, d};
    tail[r]++;
    sb.push_back('{r: r, d: d});
  endtask

  // Requester drivers: present the head byte, pop it after an accepting edge.
  initial begin
    logic [N-1:0]   acc, v, l;
    logic [8*N-1:0] d;
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) head[i]++;
        v[i] = 1'b0;
        l[i] = 1'b0;
        d[i*8 +: 8] = 8'h00;
        if (head[i] < tail[i]) begin
          v[i] = 1'b1;
          {l[i], d[i*8 +: 8]} = mem[i][head[i]];
        end
      end
      bus.req_valid = v;
      bus.req_last  = l;
      bus.req_data  = d;
    end
  end

  // Transmitter model: busy rises the cycle after tx_start, lasts about a frame.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_en && bus.tx_start === 1'b1) begin
        @(posedge clk);
        #1 bus.tx_busy = 1'b1;
        repeat (frame - 1) @(posedge clk);
        #1 bus.tx_busy = 1'b0;
      end
    end
  end

  // Monitor: scoreboard pop on every tx_start, ready one-hot / busy overlap.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) if (bus.req_ready[i] === 1'b1) ready_cyc[i]++;
      n_cmp++;
      if ($countones(bus.req_ready) > 1 || (bus.req_ready !== '0 && bus.tx_busy === 1'b1)) begin
        n_err++;
        $display("FAIL ready_excl: req_ready=%b tx_busy=%b required at most one ready and none while busy",
                 bus.req_ready, bus.tx_busy);
      end
      if (bus.tx_start === 1'b1) begin
        start_cnt++;
        start_cyc.push_back(cyc);
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: tx_start data=%02h grant=%b required no transmission",
                   bus.tx_data, bus.grant);
        end else begin
          e = sb.pop_front();
          if (bus.tx_data !== e.d || bus.grant !== (N'(1) << e.r)) begin
            n_err++;
            $display("FAIL sb_byte: data=%02h grant=%b required data=%02h grant=%b",
                     bus.tx_data, bus.grant, e.d, N'(1) << e.r);
          end else begin
            $display("[%0t] tx req=%0d data=%02h", $time, e.r, e.d);
          end
        end
      end
    end
  end

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && bus.active === 1'b0 && bus.tx_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready !== '0 || bus.tx_start !== 1'b0 || bus.tx_data !== 8'h00 ||
        bus.grant !== '0 || bus.active !== 1'b0) begin
      n_err++;
      $display("FAIL reset_vals: ready=%b start=%b data=%02h grant=%b active=%b required all zero",
               bus.req_ready, bus.tx_start, bus.tx_data, bus.grant, bus.active);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    int s0;
    frame = 20;
    s0 = start_cnt;
    load(1, 8'hA5, 1'b0);
    load(1, 8'h5A, 1'b0);
    load(1, 8'h3C, 1'b1);
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (bus.active === 1'b1) begin
        n_cmp++;
        if (bus.grant !== 4'b0010) begin
          n_err++;
          $display("FAIL single_grant: grant=%b required 0010", bus.grant);
        end
      end
      if (sb.size() == 0 && bus.active === 1'b0 && bus.tx_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL single_timeout: pending=%0d required 0", sb.size());
    end
    n_cmp++;
    if (start_cnt - s0 != 3) begin
      n_err++;
      $display("FAIL single_starts: starts=%0d required 3", start_cnt - s0);
    end
    n_cmp++;
    if (bus.grant !== '0 || dut.rr_ptr_q !== 2'd2) begin
      n_err++;
      $display("FAIL single_release: grant=%b ptr=%0d required grant 0000 ptr 2",
               bus.grant, dut.rr_ptr_q);
    end
  endtask

  task automatic test_all_four();
    bit ok;
    frame = 6;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) ready_cyc[i] = 0;
    for (int i = 0; i < N; i++) load(i, 8'h10 + 8'(i), 1'b1);
    for (int i = 0; i < N; i++) load(i, 8'h20 + 8'(i), 1'b1);
    wait_done(2000, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL all4_timeout: pending=%0d required 0", sb.size());
    end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (ready_cyc[i] != 2) begin
        n_err++;
        $display("FAIL all4_ready_pulses: req=%0d ready_cycles=%0d required 2", i, ready_cyc[i]);
      end
    end
  endtask

  task automatic test_max_burst();
    bit ok;
    frame = 6;
    for (int k = 0; k < 16; k++) load(2, 8'h40 + 8'(k), 1'b0);
    load(3, 8'hC0, 1'b0);
    load(3, 8'hC1, 1'b1);
    // Reorder expectations: requester 3's packet lands between the bursts.
    sb.delete();
    for (int k = 0; k < 16; k++) sb.push_back('{r: 2, d: 8'h40 + 8'(k)});
    sb.push_back('{r: 3, d: 8'hC0});
    sb.push_back('{r: 3, d: 8'hC1});
    for (int k = 16; k < 20; k++) begin
      mem[2][tail[2]] = {1'b0, 8'h40 + 8'(k)};
      tail[2]++;
      sb.push_back('{r: 2, d: 8'h40 + 8'(k)});
    end
    wait_done(4000, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL burst_timeout: pending=%0d required 0", sb.size());
    end
  endtask

  task automatic test_gap_timeout();
    bit ok;
    bit seen;
    int n;
    frame = 6;
    load(0, 8'h77, 1'b0);
    load(1, 8'h88, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (sb.size() == 1 && bus.req_ready[0] === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL gap_regrant: req_ready=%b required requester 0 back in GRANT", bus.req_ready);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.active === 1'b1 && n < 50);
    n_cmp++;
    if (n != 8) begin
      n_err++;
      $display("FAIL gap_release: idle_cycles=%0d required 8", n);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.grant !== 4'b0010) begin
      n_err++;
      $display("FAIL gap_next_grant: grant=%b required 0010", bus.grant);
    end
    wait_done(500, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL gap_timeout_wait: pending=%0d required 0", sb.size());
    end
  endtask

  task automatic test_no_busy();
    bit ok;
    int b;
    busy_en = 1'b0;
    b = start_cyc.size();
    load(3, 8'hE1, 1'b0);
    load(3, 8'hE2, 1'b0);
    load(3, 8'hE3, 1'b1);
    wait_done(300, ok);
    n_cmp++;
    if (!ok || start_cyc.size() - b != 3) begin
      n_err++;
      $display("FAIL nobusy_done: ok=%0d starts=%0d required completion with 3 starts",
               ok, start_cyc.size() - b);
    end else begin
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (start_cyc[b+k+1] - start_cyc[b+k] != 4) begin
          n_err++;
          $display("FAIL nobusy_spacing: gap=%0d required 4",
                   start_cyc[b+k+1] - start_cyc[b+k]);
        end
      end
    end
    busy_en = 1'b1;
  endtask

  task automatic test_reset_midpacket();
    bit ok;
    bit seen;
    int s0;
    frame = 20;
    s0 = start_cnt;
    for (int k = 0; k < 4; k++) load(2, 8'h91 + 8'(k), k == 3);
    seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (start_cnt - s0 >= 2 && bus.tx_busy === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL midrst_reach: starts=%0d required 2 starts with busy high", start_cnt - s0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.req_ready !== '0 || bus.tx_start !== 1'b0 || bus.tx_data !== 8'h00 ||
        bus.grant !== '0 || bus.active !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_async: ready=%b start=%b data=%02h grant=%b active=%b required all zero",
               bus.req_ready, bus.tx_start, bus.tx_data, bus.grant, bus.active);
    end
    for (int i = 0; i < N; i++) head[i] = tail[i];
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load(0, 8'hA0, 1'b1);
    load(2, 8'hA2, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.active === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!seen || bus.grant !== 4'b0001) begin
      n_err++;
      $display("FAIL midrst_first_grant: grant=%b required 0001", bus.grant);
    end
    wait_done(1000, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL midrst_timeout: pending=%0d required 0", sb.size());
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) ready_cyc[i] = 0;
    test_reset();
    test_single();
    test_all_four();
    test_max_burst();
    test_gap_timeout();
    test_no_busy();
    test_reset_midpacket();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
